// File: rtl/neander_mem_if.sv
// rtl/neander_mem_if.sv - request/acknowledge bus between the Neander datapath and its memory
interface neander_mem_if;
  logic       req;
  logic       we;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic [7:0] rem;
  logic       ack;
  logic       busy;

  modport master (output req, we, addr, wdata, input rdata, rem, ack, busy);
  modport slave  (input req, we, addr, wdata, output rdata, rem, ack, busy);
endinterface

// File: rtl/neander_mem.sv
// rtl/neander_mem.sv - 256x8 memory responder with REM/RDM latches and configurable wait states
module neander_mem #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic         clock,
  input  logic         nreset,
  neander_mem_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;

  localparam logic [1:0] WS = WAIT_STATES[1:0];

  state_t     state, state_nx;
  logic [1:0] cnt;
  logic [7:0] rem_q;
  logic [7:0] wreg;
  logic [7:0] rdata_q;
  logic       we_l;
  logic       capture;
  logic [7:0] mem [256];

  if (WAIT_STATES > 3) begin : g_ws_check
    $error("neander_mem: WAIT_STATES must be in 0..3");
  end

  // DONE accepts a fresh request on its closing edge, giving back-to-back accesses
  assign capture = bus.req && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (bus.req) state_nx = (WS != 2'd0) ? WAIT : XFER;
        else         state_nx = IDLE;
      end
      WAIT:    if (cnt == 2'd1) state_nx = XFER;
      XFER:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      rem_q   <= 8'h00;
      wreg    <= 8'h00;
      we_l    <= 1'b0;
      cnt     <= 2'd0;
      rdata_q <= 8'h00;
    end else begin
      if (capture) begin
        rem_q <= bus.addr;
        wreg  <= bus.wdata;
        we_l  <= bus.we;
        cnt   <= WS;
      end else if (state == WAIT) begin
        cnt <= cnt - 2'd1;
      end
      if ((state == XFER) && !we_l) rdata_q <= mem[rem_q];
    end
  end

  // array has no reset so its contents survive nreset
  always_ff @(posedge clock) begin
    if (nreset && (state == XFER) && we_l) mem[rem_q] <= wreg;
  end

  assign bus.rdata = rdata_q;
  assign bus.rem   = rem_q;
  assign bus.ack   = (state == DONE);
  assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_neander_mem.sv
// tb/tb_neander_mem.sv - randomized self-checking bench for neander_mem at WAIT_STATES 0, 1 and 3
module tb_neander_mem;

  logic       clock = 1'b0;
  logic       nreset = 1'b0;
  logic       req_d   [3];
  logic       we_d    [3];
  logic [7:0] addr_d  [3];
  logic [7:0] wdata_d [3];
  logic [7:0] rdata_o [3];
  logic [7:0] rem_o   [3];
  logic       ack_o   [3];
  logic       busy_o  [3];

  int checks = 0;
  int errors = 0;

  // reference model: memory image per device plus the value RDM should hold
  logic [7:0] mmem  [3][256];
  bit         known [3][256];
  logic [7:0] mrd   [3];

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned WS = (g == 0) ? 0 : (g == 1) ? 1 : 3;
    neander_mem_if bus ();
    assign bus.req   = req_d[g];
    assign bus.we    = we_d[g];
    assign bus.addr  = addr_d[g];
    assign bus.wdata = wdata_d[g];
    assign rdata_o[g] = bus.rdata;
    assign rem_o[g]   = bus.rem;
    assign ack_o[g]   = bus.ack;
    assign busy_o[g]  = bus.busy;
    neander_mem #(.WAIT_STATES(WS)) u_dut (
      .clock  (clock),
      .nreset (nreset),
      .bus    (bus)
    );
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 1 : 3;
  endfunction

  task automatic run_access(input int d, input bit wr, input logic [7:0] a,
                            input logic [7:0] wd, input bit glitch, output int lat);
    int         busy_cnt;
    bit         got;
    logic [7:0] exp_rd;
    @(negedge clock);
    we_d[d] = wr; addr_d[d] = a; wdata_d[d] = wd; req_d[d] = 1'b1;
    @(posedge clock);
    got = 0; lat = 0; busy_cnt = 0;
    for (int n = 1; n <= 12 && !got; n++) begin
      @(negedge clock);
      if (busy_o[d]) busy_cnt++;
      checks++;
      if (rem_o[d] !== a) begin
        errors++; $display("FAIL rem d%0d cyc%0d: got %h expected %h", d, n, rem_o[d], a);
      end
      if (ack_o[d]) begin
        got = 1; lat = n;
        exp_rd = wr ? mrd[d] : mmem[d][a];
      end else begin
        exp_rd = mrd[d];
      end
      checks++;
      if (rdata_o[d] !== exp_rd) begin
        errors++; $display("FAIL rdata d%0d cyc%0d: got %h expected %h", d, n, rdata_o[d], exp_rd);
      end
      if (n == 1) begin
        req_d[d] = 1'b0;
        if (glitch) begin addr_d[d] = 8'hFF; we_d[d] = 1'b1; wdata_d[d] = 8'($urandom); end
      end
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL timeout d%0d: got no ack expected ack within 12 cycles", d);
    end
    checks++;
    if (lat != ws_of(d) + 2) begin
      errors++; $display("FAIL latency d%0d: got %0d expected %0d", d, lat, ws_of(d) + 2);
    end
    checks++;
    if (busy_cnt != ws_of(d) + 2) begin
      errors++; $display("FAIL busy_len d%0d: got %0d expected %0d", d, busy_cnt, ws_of(d) + 2);
    end
    if (wr) begin mmem[d][a] = wd; known[d][a] = 1; end
    else    mrd[d] = mmem[d][a];
    @(negedge clock);
    checks++;
    if (busy_o[d] !== 1'b0 || ack_o[d] !== 1'b0) begin
      errors++; $display("FAIL idle_after d%0d: got busy=%b ack=%b expected 0 0", d, busy_o[d], ack_o[d]);
    end
    we_d[d] = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (rem_o[d] !== 8'h00 || rdata_o[d] !== 8'h00 || ack_o[d] !== 1'b0 || busy_o[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset d%0d: got rem=%h rdata=%h ack=%b busy=%b expected 00 00 0 0",
                 d, rem_o[d], rdata_o[d], ack_o[d], busy_o[d]);
      end
    end
    @(negedge clock);
    nreset = 1'b1;
  endtask

  task automatic test_write_read();
    int lat;
    run_access(1, 1'b1, 8'h80, 8'hA5, 1'b0, lat);
    run_access(1, 1'b0, 8'h80, 8'h00, 1'b0, lat);
    checks++;
    if (rdata_o[1] !== 8'hA5) begin
      errors++; $display("FAIL wr_rd_80: got %h expected a5", rdata_o[1]);
    end
  endtask

  task automatic test_latency();
    int lat;
    run_access(0, 1'b1, 8'h42, 8'h9E, 1'b0, lat);
    run_access(0, 1'b0, 8'h42, 8'h00, 1'b0, lat);
    checks++;
    if (lat != 2) begin errors++; $display("FAIL lat_ws0: got %0d expected 2", lat); end
    run_access(2, 1'b1, 8'h42, 8'h3B, 1'b0, lat);
    run_access(2, 1'b0, 8'h42, 8'h00, 1'b0, lat);
    checks++;
    if (lat != 5) begin errors++; $display("FAIL lat_ws3: got %0d expected 5", lat); end
  endtask

  task automatic test_back_to_back(input int d);
    int t1, t2;
    t1 = 0; t2 = 0;
    @(negedge clock);
    we_d[d] = 1'b1; addr_d[d] = 8'h00; wdata_d[d] = 8'h11; req_d[d] = 1'b1;
    @(posedge clock);
    for (int n = 1; n <= 20 && t2 == 0; n++) begin
      @(negedge clock);
      if (ack_o[d]) begin
        if (t1 == 0) begin
          t1 = n;
          checks++;
          if (rdata_o[d] !== mrd[d]) begin
            errors++; $display("FAIL b2b_wr_rdata d%0d: got %h expected %h", d, rdata_o[d], mrd[d]);
          end
        end else begin
          t2 = n;
        end
      end
      if (n == 1) begin we_d[d] = 1'b0; wdata_d[d] = 8'hEE; end
      if (t1 != 0 && n == t1 + 1) req_d[d] = 1'b0;
    end
    mmem[d][0] = 8'h11; known[d][0] = 1; mrd[d] = 8'h11;
    req_d[d] = 1'b0;
    checks++;
    if (t2 == 0 || t2 - t1 != ws_of(d) + 2) begin
      errors++; $display("FAIL b2b_gap d%0d: got %0d expected %0d", d, t2 - t1, ws_of(d) + 2);
    end
    checks++;
    if (rdata_o[d] !== 8'h11) begin
      errors++; $display("FAIL b2b_rdata d%0d: got %h expected 11", d, rdata_o[d]);
    end
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic test_glitch();
    int lat;
    run_access(1, 1'b1, 8'hFF, 8'h5A, 1'b0, lat);
    run_access(1, 1'b0, 8'h80, 8'h00, 1'b1, lat);
    checks++;
    if (rdata_o[1] !== 8'hA5) begin
      errors++; $display("FAIL glitch_read: got %h expected a5", rdata_o[1]);
    end
    run_access(1, 1'b0, 8'hFF, 8'h00, 1'b0, lat);
    checks++;
    if (rdata_o[1] !== 8'h5A) begin
      errors++; $display("FAIL glitch_ff: got %h expected 5a", rdata_o[1]);
    end
  endtask

  task automatic test_abort();
    int lat;
    run_access(2, 1'b1, 8'h10, 8'h77, 1'b0, lat);
    run_access(2, 1'b0, 8'h10, 8'h00, 1'b0, lat);
    @(negedge clock);
    we_d[2] = 1'b1; addr_d[2] = 8'h10; wdata_d[2] = 8'h3C; req_d[2] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (busy_o[2] !== 1'b1) begin
      errors++; $display("FAIL abort_busy: got %b expected 1", busy_o[2]);
    end
    nreset = 1'b0; req_d[2] = 1'b0; we_d[2] = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (rem_o[d] !== 8'h00 || rdata_o[d] !== 8'h00 || ack_o[d] !== 1'b0 || busy_o[d] !== 1'b0) begin
        errors++;
        $display("FAIL abort_reset d%0d: got rem=%h rdata=%h ack=%b busy=%b expected 00 00 0 0",
                 d, rem_o[d], rdata_o[d], ack_o[d], busy_o[d]);
      end
      mrd[d] = 8'h00;
    end
    @(negedge clock);
    @(negedge clock);
    nreset = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clock);
      checks++;
      if (ack_o[2] !== 1'b0) begin
        errors++; $display("FAIL abort_ack cyc%0d: got %b expected 0", n, ack_o[2]);
      end
    end
    run_access(2, 1'b0, 8'h10, 8'h00, 1'b0, lat);
    checks++;
    if (rdata_o[2] !== 8'h77) begin
      errors++; $display("FAIL abort_mem: got %h expected 77", rdata_o[2]);
    end
  endtask

  task automatic test_random();
    int         lat;
    logic [7:0] a, v, prev;
    for (int d = 0; d < 3; d++) begin
      prev = 8'h00;
      for (int i = 0; i < 8; i++) begin
        a = 8'($urandom); v = 8'($urandom);
        run_access(d, 1'b1, a, v, 1'b0, lat);
        run_access(d, 1'b0, a, 8'($urandom), 1'b0, lat);
        if (i > 0 && ($urandom_range(0, 1) == 1)) run_access(d, 1'b0, prev, 8'h00, 1'b0, lat);
        prev = a;
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      req_d[d] = 1'b0; we_d[d] = 1'b0; addr_d[d] = 8'h00; wdata_d[d] = 8'h00;
      mrd[d] = 8'h00;
      for (int a = 0; a < 256; a++) begin mmem[d][a] = 8'h00; known[d][a] = 0; end
    end
    test_reset();
    test_write_read();
    test_latency();
    for (int d = 0; d < 3; d++) test_back_to_back(d);
    test_glitch();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/neander_mem.md
# neander_mem

Synchronous 256 x 8 memory responder for the Neander datapath: the target end of the address/data path driven by the program counter and the address-register mux. It latches an access request (address, write data, direction) into its own REM/RDM pair, inserts a configurable number of wait states, performs the read or write, and returns a one-cycle acknowledge. Read data is held in RDM until the next completed read.

## Interface
- WAIT_STATES, 1, wait cycles inserted between request capture and transfer; legal range 0..3.
- clock  input  1  system clock, all state updates on rising edge.
- nreset  input  1  asynchronous, active-low reset.
- req  input  1  access request, sampled only in IDLE or DONE.
- we  input  1  1 = write, 0 = read; sampled with req.
- addr  input  8  access address (from PC or operand path), sampled with req.
- wdata  input  8  write data (from AC), sampled with req.
- rdata  output  8  RDM contents; updated only on a completed read.
- rem  output  8  currently latched address (REM), for debug/datapath display.
- ack  output  1  one-cycle pulse: transfer completed this cycle.
- busy  output  1  high from request capture until the ack cycle inclusive.

## Operation
- States: IDLE, WAIT, XFER, DONE.
- IDLE: busy=0, ack=0. Edge with req=1: REM<=addr, WREG<=wdata, WE_L<=we, cnt<=WAIT_STATES; next state WAIT if WAIT_STATES>0, else XFER.
- WAIT: busy=1. Each edge cnt<=cnt-1; when cnt==1 at the edge, next state XFER. addr/wdata/we/req ignored.
- XFER: busy=1. On the edge leaving XFER: if WE_L, mem[REM]<=WREG (rdata unchanged); else rdata<=mem[REM]. Next state DONE.
- DONE: ack=1, busy=1 for exactly this cycle. Edge with req=1: new capture exactly as in IDLE (back-to-back). Edge with req=0: IDLE.
- Address arithmetic: 8-bit, no wrap logic needed; all 256 locations valid.
- Memory array is not cleared by reset; contents persist across reset.
- Read of a location written in the immediately preceding access returns the new value.
- WAIT_STATES outside 0..3 is a configuration error (simulation assertion).

## Timing
- Reset (async, nreset=0): state=IDLE, rem=0x00, rdata=0x00, ack=0, busy=0, cnt=0, WREG=0, WE_L=0. Release is synchronous to next edge; first request may be sampled on the first edge with nreset=1.
- Latency: req sampled at edge k -> busy=1 from after edge k; write/read effect at edge k+WAIT_STATES+1; ack=1 and rdata valid in cycle after edge k+WAIT_STATES+1.
- Throughput: back-to-back accesses every WAIT_STATES+2 cycles when req held high through DONE.
- Initiator must hold req only for the capture edge or drop it during the ack cycle; req=1 in DONE is always a new request, never a repeat of the old one.
- Inputs changing during WAIT/XFER have no effect on the in-flight access.
- Reset asserted in WAIT or XFER aborts: no memory write occurs unless the write edge already passed; rdata returns to 0x00; ack never pulses for the aborted access.
- ack and busy are registered outputs (no combinational path from req).

## Test plan
- Reset: nreset=0 mid-run -> rem=0x00, rdata=0x00, ack=0, busy=0 immediately, without a clock edge.
- Write/read, WAIT_STATES=1: write 0xA5 to 0x80 (req at edge k) -> ack high after edge k+2; read 0x80 -> rdata=0xA5 with ack, busy high 3 cycles.
- WAIT_STATES=0 and 3: read latency measured -> ack after edge k+1 and k+4 respectively.
- Back-to-back: req held high, write 0x11 @0x00, then read 0x00 -> second ack exactly WAIT_STATES+2 cycles after first, rdata=0x11.
- Input glitch: during WAIT change addr to 0xFF and we to 1 -> original read of 0x80 completes, mem[0xFF] unchanged, rem stays 0x80.
- Abort: assert nreset in WAIT of a write 0x3C @0x10 -> no ack, mem[0x10] keeps prior value; after release read 0x10 returns prior value.
